fetch_pc_responder: RTL and testbench
=====================================

Name: fetch_pc_responder

Overview:
- Responder side of the multicycle control-unit handshake.
- Services the control unit's level-held instruction-fetch request (instrfetch) and PC-write request (PCwrite).
- Owns the architectural PC and the instruction register; drives the instruction-memory read port.
- Returns single-cycle completion pulses (instr_fetched, pc_update) that advance the control FSM.

Parameters:
- RESET_PC, 32'h0100_0000, PC value loaded on reset.
- TIMEOUT, 16, cycles to wait for imem_valid before aborting a fetch.
- NOP_INSTR, 32'h0000_0013, value loaded into instr on reset and on fetch timeout (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instrfetch  in  1  fetch request; held high by the control unit until instr_fetched is seen
- PCwrite  in  1  PC-update request; held high until pc_update is seen
- branch_taken  in  1  select branch_target as the next PC (sampled when the PCwrite request is accepted)
- branch_target  in  32  branch/jump target address
- halt  in  1  stop servicing requests
- imem_req  out  1  one-cycle read strobe to instruction memory
- imem_addr  out  32  read address, equal to pc
- imem_rdata  in  32  read data
- imem_valid  in  1  read data valid; may be high in the same cycle as imem_req
- instr  out  32  latched instruction
- pc  out  32  current PC
- instr_fetched  out  1  one-cycle fetch-complete pulse
- pc_update  out  1  one-cycle PC-update-complete pulse
- misaligned  out  1  sticky: a branch target was not 4-byte aligned
- fetch_err  out  1  sticky: a fetch timed out

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE, pc=RESET_PC, instr=NOP_INSTR
  - imem_req, instr_fetched, pc_update, misaligned, fetch_err = 0
  - timeout counter = 0
- All outputs are registered.
- States: IDLE, IMEM_REQ, IMEM_WAIT, FETCH_DONE, PC_DONE, WAIT_DROP, HALTED.
- IDLE:
  - halt -> HALTED.
  - Else PCwrite -> PC_DONE (PCwrite has priority when both requests are high).
  - Else instrfetch -> IMEM_REQ.
  - Else stay in IDLE.
- PC update, PCwrite accepted at edge k:
  - at edge k+1, pc <= next_pc, and pc_update=1 for cycle k+1 only.
  - next_pc = branch_taken ? {branch_target[31:1],1'b0} : pc+32'd4. The +4 wraps modulo 2^32 (FFFF_FFFC -> 0000_0000).
  - If branch_taken and branch_target[1]=1: pc is left unchanged, misaligned <= 1, and pc_update still pulses so the control FSM cannot hang.
- Fetch, instrfetch accepted at edge k:
  - IMEM_REQ: imem_req=1 for exactly cycle k+1; imem_addr=pc is held stable for the whole fetch.
  - imem_valid is sampled every cycle from k+1 onward, including the IMEM_REQ cycle.
  - At the first edge with imem_valid=1: instr <= imem_rdata, go to FETCH_DONE.
  - Zero-wait case: instr_fetched is high in cycle k+2.
  - Each cycle in IMEM_WAIT without imem_valid increments the counter.
  - When the counter reaches TIMEOUT: instr <= NOP_INSTR, fetch_err <= 1, go to FETCH_DONE.
  - The counter is cleared on entering IMEM_REQ.
- FETCH_DONE / PC_DONE:
  - The matching completion output is high for exactly this one cycle.
  - Next state is WAIT_DROP.
- WAIT_DROP:
  - Returns to IDLE only after a cycle in which both instrfetch=0 and PCwrite=0.
  - A request still held high is never serviced twice.
- halt in any non-HALTED state -> HALTED at the next edge.
  - An in-flight fetch is abandoned and instr is not updated.
  - A pending completion pulse is suppressed.
- HALTED:
  - imem_req, instr_fetched, pc_update = 0; pc and instr hold.
  - Exits only on rst.
- An imem_valid seen outside IMEM_REQ/IMEM_WAIT is ignored.
- misaligned and fetch_err clear only on rst.

Decomposition:
- Shared package (rv32i_ctrl_pkg): state encoding constants, NOP_INSTR, RESET_PC default, and the PC increment constant 4.
- One natural sub-module: fetch_timeout_counter (clear, enable, terminal-count flag).
- The PC register and the next-PC logic stay in the top module.

Test Plan:
- Reset: assert rst mid-IMEM_WAIT -> pc=0100_0000, instr=0000_0013, all strobes 0 immediately, without waiting for a clock edge.
- Zero-wait fetch: pc=0100_0000; instrfetch high at edge 0; imem_valid with rdata=0030_0093 in cycle 1 -> imem_req in cycle 1 only, instr=0030_0093, instr_fetched pulse in cycle 2 only.
- Wait-state and timeout:
  - imem_valid 3 cycles late -> a single imem_req, instr_fetched 1 cycle after valid.
  - imem_valid never asserted -> instr=0000_0013 and fetch_err=1 after 16 wait cycles.
- PC update: PCwrite with branch_taken=0 at pc=FFFF_FFFC -> pc=0000_0000; branch_taken=1, target=0100_0041 -> pc=0100_0040; target=0100_0042 -> pc unchanged, misaligned=1, pc_update still pulses.
- Held request and priority:
  - instrfetch held high 3 cycles after instr_fetched -> no second imem_req until instrfetch drops.
  - instrfetch and PCwrite high together -> pc_update first, then the fetch after both drop.
- Halt: halt asserted in IMEM_WAIT -> no instr_fetched, instr unchanged, no further imem_req or pc_update until rst.

Source files
------------

// File: rtl/rv32i_ctrl_pkg.sv
// rtl/rv32i_ctrl_pkg.sv - shared state encoding and constants for the fetch/PC responder
package rv32i_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_IMEM_REQ   = 3'd1,
        ST_IMEM_WAIT  = 3'd2,
        ST_FETCH_DONE = 3'd3,
        ST_PC_DONE    = 3'd4,
        ST_WAIT_DROP  = 3'd5,
        ST_HALTED     = 3'd6
    } state_e;

    localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_C  = 32'h0100_0000;
    localparam logic [31:0] PC_INCR     = 32'd4;

    // Jump targets drop bit 0 like JALR; bit 1 is left for the alignment check.
    function automatic logic [31:0] branch_dest(input logic [31:0] target);
        return {target[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// rtl/fetch_timeout_counter.sv - counts fetch wait cycles and flags the one that reaches the limit
module fetch_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0]   LAST  = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Clear wins over counting; the count saturates at the limit.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_d = count_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // High during the wait cycle whose increment brings the count to the limit.
    assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/fetch_pc_responder.sv
// rtl/fetch_pc_responder.sv - services control-unit fetch and PC-write requests, owns pc and instr
module fetch_pc_responder
    import rv32i_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_C,
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instrfetch,
    input  logic        PCwrite,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        instr_fetched,
    output logic        pc_update,
    output logic        misaligned,
    output logic        fetch_err
);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        bad_target;
    logic [31:0] instr_q;
    logic        imem_req_q;
    logic        instr_fetched_q;
    logic        pc_update_q;
    logic        misaligned_q;
    logic        fetch_err_q;

    logic        tmr_clear;
    logic        tmr_enable;
    logic        tmr_expired;

    // Next PC: aligned branch target or sequential +4 (wraps naturally at 32 bits).
    always_comb begin
        bad_target = branch_taken && branch_target[1];
        pc_d       = pc_q + PC_INCR;
        if (branch_taken) begin
            pc_d = bad_target ? pc_q : branch_dest(branch_target);
        end
    end

    // Timer control: cleared as a fetch is accepted, counts IMEM_WAIT cycles without data.
    always_comb begin
        tmr_clear  = (state_q == ST_IDLE) && !halt && !PCwrite && instrfetch;
        tmr_enable = (state_q == ST_IMEM_WAIT) && !halt && !imem_valid;
    end

    fetch_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    // Handshake FSM; every output is a register written here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            pc_q            <= RESET_PC;
            instr_q         <= NOP_INSTR;
            imem_req_q      <= 1'b0;
            instr_fetched_q <= 1'b0;
            pc_update_q     <= 1'b0;
            misaligned_q    <= 1'b0;
            fetch_err_q     <= 1'b0;
        end else begin
            imem_req_q      <= 1'b0;
            instr_fetched_q <= 1'b0;
            pc_update_q     <= 1'b0;
            if (halt && (state_q != ST_HALTED)) begin
                // Abandons any fetch in flight and swallows its completion pulse.
                state_q <= ST_HALTED;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (PCwrite) begin
                            pc_q        <= pc_d;
                            pc_update_q <= 1'b1;
                            if (bad_target) begin
                                misaligned_q <= 1'b1;
                            end
                            state_q <= ST_PC_DONE;
                        end else if (instrfetch) begin
                            imem_req_q <= 1'b1;
                            state_q    <= ST_IMEM_REQ;
                        end
                    end
                    ST_IMEM_REQ: begin
                        if (imem_valid) begin
                            instr_q         <= imem_rdata;
                            instr_fetched_q <= 1'b1;
                            state_q         <= ST_FETCH_DONE;
                        end else begin
                            state_q <= ST_IMEM_WAIT;
                        end
                    end
                    ST_IMEM_WAIT: begin
                        if (imem_valid) begin
                            instr_q         <= imem_rdata;
                            instr_fetched_q <= 1'b1;
                            state_q         <= ST_FETCH_DONE;
                        end else if (tmr_expired) begin
                            instr_q         <= NOP_INSTR;
                            fetch_err_q     <= 1'b1;
                            instr_fetched_q <= 1'b1;
                            state_q         <= ST_FETCH_DONE;
                        end
                    end
                    ST_FETCH_DONE, ST_PC_DONE: begin
                        state_q <= ST_WAIT_DROP;
                    end
                    ST_WAIT_DROP: begin
                        // A request still held from the last transaction must not restart it.
                        if (!instrfetch && !PCwrite) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_HALTED: begin
                        state_q <= ST_HALTED;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign imem_req      = imem_req_q;
    assign imem_addr     = pc_q;
    assign instr         = instr_q;
    assign pc            = pc_q;
    assign instr_fetched = instr_fetched_q;
    assign pc_update     = pc_update_q;
    assign misaligned    = misaligned_q;
    assign fetch_err     = fetch_err_q;

endmodule

// File: tb/tb_fetch_pc_responder.sv
// tb/tb_fetch_pc_responder.sv - randomized self-checking bench for fetch_pc_responder
module tb_fetch_pc_responder;

    localparam logic [31:0] RST_PC = 32'h0100_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          TMO    = 16;
    localparam int          NEVER  = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instrfetch = 1'b0;
    logic        PCwrite = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        halt = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_valid = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_fetched;
    logic        pc_update;
    logic        misaligned;
    logic        fetch_err;

    int n_checks = 0;
    int n_errors = 0;

    // Architectural reference state.
    logic [31:0] pc_m;
    logic [31:0] instr_m;
    logic        mis_m;
    logic        ferr_m;

    fetch_pc_responder dut (
        .clk           (clk),
        .rst           (rst),
        .instrfetch    (instrfetch),
        .PCwrite       (PCwrite),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt          (halt),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .instr         (instr),
        .pc            (pc),
        .instr_fetched (instr_fetched),
        .pc_update     (pc_update),
        .misaligned    (misaligned),
        .fetch_err     (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        pc_m    = RST_PC;
        instr_m = NOP;
        mis_m   = 1'b0;
        ferr_m  = 1'b0;
    endtask

    task automatic check_arch(input string tag);
        check_eq({tag, ".pc"}, pc, pc_m);
        check_eq({tag, ".instr"}, instr, instr_m);
        check_eq({tag, ".misaligned"}, 32'(misaligned), 32'(mis_m));
        check_eq({tag, ".fetch_err"}, 32'(fetch_err), 32'(ferr_m));
    endtask

    // One fetch: data arrives lat cycles after the request cycle (NEVER = no data);
    // the request is held for hold extra cycles after the completion pulse.
    task automatic do_fetch(input string tag, input int lat, input int hold, input logic [31:0] rd);
        int req_n = 0;
        int req_c = -1;
        int done_n = 0;
        int done_c = -1;
        int upd_n = 0;
        int drop_c = -1;
        int exp_c;
        logic [31:0] addr_s = 32'hx;
        if (lat <= TMO) begin
            exp_c   = lat + 2;
            instr_m = rd;
        end else begin
            exp_c   = TMO + 2;
            instr_m = NOP;
            ferr_m  = 1'b1;
        end
        @(negedge clk);
        instrfetch = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (imem_req) begin
                req_n++;
                if (req_c < 0) req_c = c;
                addr_s = imem_addr;
            end
            if (pc_update) upd_n++;
            if (instr_fetched) begin
                done_n++;
                if (done_c < 0) done_c = c;
            end
            if (drop_c >= 0 && c >= drop_c + 2) break;
            if (done_c >= 0 && drop_c < 0 && c >= done_c + hold) begin
                instrfetch = 1'b0;
                drop_c     = c;
            end
            imem_valid = (c == lat + 1);
            imem_rdata = imem_valid ? rd : $urandom;
        end
        imem_valid = 1'b0;
        if (drop_c < 0) begin
            instrfetch = 1'b0;
            repeat (2) @(negedge clk);
        end
        check_eq({tag, ".req_count"}, req_n, 1);
        check_eq({tag, ".req_cycle"}, req_c, 1);
        check_eq({tag, ".req_addr"}, addr_s, pc_m);
        check_eq({tag, ".done_count"}, done_n, 1);
        check_eq({tag, ".done_cycle"}, done_c, exp_c);
        check_eq({tag, ".stray_pc_update"}, upd_n, 0);
        check_arch(tag);
    endtask

    // One PC write; branch inputs are scrambled after acceptance to show they were sampled once.
    task automatic do_pcw(input string tag, input logic br, input logic [31:0] tgt, input int hold);
        int upd_n = 0;
        int upd_c = -1;
        int req_n = 0;
        int drop_c = -1;
        if (br) begin
            if (tgt[1]) mis_m = 1'b1;
            else        pc_m  = {tgt[31:1], 1'b0};
        end else begin
            pc_m = pc_m + 32'd4;
        end
        @(negedge clk);
        PCwrite       = 1'b1;
        branch_taken  = br;
        branch_target = tgt;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (pc_update) begin
                upd_n++;
                if (upd_c < 0) upd_c = c;
            end
            if (imem_req) req_n++;
            if (drop_c >= 0 && c >= drop_c + 2) break;
            if (upd_c >= 0 && drop_c < 0 && c >= upd_c + hold) begin
                PCwrite = 1'b0;
                drop_c  = c;
            end
            branch_taken  = 1'($urandom);
            branch_target = $urandom;
        end
        PCwrite      = 1'b0;
        branch_taken = 1'b0;
        check_eq({tag, ".upd_count"}, upd_n, 1);
        check_eq({tag, ".upd_cycle"}, upd_c, 1);
        check_eq({tag, ".stray_req"}, req_n, 0);
        check_arch(tag);
    endtask

    initial begin
        int upd_n;
        int req_n;
        int done_n;
        int upd_c;
        logic [31:0] tgt;

        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_held.imem_req", 32'(imem_req), 0);
        check_eq("rst_held.instr_fetched", 32'(instr_fetched), 0);
        check_eq("rst_held.pc_update", 32'(pc_update), 0);
        check_arch("rst_held");
        rst = 1'b0;
        @(negedge clk);

        do_fetch("zero_wait", 0, 0, 32'h0030_0093);
        do_fetch("wait3_hold3", 3, 3, $urandom);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1, 0) == 0) begin
                do_fetch("rnd_fetch", $urandom_range(12, 0), $urandom_range(3, 0), $urandom);
            end else begin
                tgt = $urandom;
                if ($urandom_range(3, 0) != 0) tgt[1] = 1'b0;
                do_pcw("rnd_pcw", 1'($urandom), tgt, $urandom_range(3, 0));
            end
        end

        do_fetch("wait16_edge", 16, 0, $urandom);
        do_pcw("to_top", 1'b1, 32'hFFFF_FFFC, 0);
        do_pcw("wrap", 1'b0, 32'h0, 0);
        check_eq("wrap.zero", pc, 32'h0000_0000);
        do_pcw("br_odd", 1'b1, 32'h0100_0041, 1);
        check_eq("br_odd.value", pc, 32'h0100_0040);
        do_pcw("br_misaligned", 1'b1, 32'h0100_0042, 0);
        check_eq("br_misaligned.hold", pc, 32'h0100_0040);
        do_fetch("timeout", NEVER, 1, $urandom);

        // Both requests together: PC write first, fetch only after both drop.
        upd_n = 0;
        req_n = 0;
        upd_c = -1;
        pc_m  = pc_m + 32'd4;
        @(negedge clk);
        instrfetch = 1'b1;
        PCwrite    = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (pc_update) begin
                upd_n++;
                if (upd_c < 0) upd_c = c;
            end
            if (imem_req) req_n++;
            if (c == 3) PCwrite = 1'b0;
        end
        instrfetch = 1'b0;
        check_eq("prio.upd_count", upd_n, 1);
        check_eq("prio.upd_cycle", upd_c, 1);
        check_eq("prio.held_req", req_n, 0);
        @(negedge clk);
        do_fetch("prio_fetch", 1, 0, $urandom);

        // Asynchronous reset mid-wait, with both sticky flags already set.
        check_eq("pre_rst.misaligned", 32'(misaligned), 1);
        check_eq("pre_rst.fetch_err", 32'(fetch_err), 1);
        @(negedge clk);
        instrfetch = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("async_rst.imem_req", 32'(imem_req), 0);
        check_eq("async_rst.instr_fetched", 32'(instr_fetched), 0);
        check_eq("async_rst.pc_update", 32'(pc_update), 0);
        check_arch("async_rst");
        instrfetch = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Halt while waiting for data: nothing completes and nothing restarts.
        do_pcw("pre_halt", 1'b0, 32'h0, 0);
        do_fetch("pre_halt_fetch", 0, 0, $urandom);
        upd_n  = 0;
        req_n  = 0;
        done_n = 0;
        @(negedge clk);
        instrfetch = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c >= 4) begin
                if (pc_update) upd_n++;
                if (imem_req) req_n++;
                if (instr_fetched) done_n++;
            end
            if (c == 3) halt = 1'b1;
            if (c == 6) halt = 1'b0;
            if (c >= 4) begin
                imem_valid = 1'b1;
                imem_rdata = $urandom;
                PCwrite    = (c >= 8);
                instrfetch = (c < 10);
            end
        end
        imem_valid = 1'b0;
        PCwrite    = 1'b0;
        instrfetch = 1'b0;
        check_eq("halt.no_done", done_n, 0);
        check_eq("halt.no_req", req_n, 0);
        check_eq("halt.no_upd", upd_n, 0);
        check_arch("halt");

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_arch("post_halt_rst");
        do_fetch("post_halt_fetch", 2, 0, $urandom);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
